// File: rtl/inbuf_vc.sv
// inbuf_vc -- per-VC input flit buffer in front of route computation.
//
// Buffers incoming flits in a small circular FIFO. When a head flit reaches
// the front, raises a one-cycle rc_en with the destination address and VC
// id. After one cycle for route computation, the packet's flits are
// forwarded to the switch stage until the tail is popped. Each pop returns
// one credit upstream on the following cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_     synchronous reset, active-low
//   idata    incoming flit payload
//   itype    incoming flit type (00 body, 01 head, 10 tail, 11 head+tail)
//   ivalid   push request; upstream holds a credit
//   addr     front flit payload low bits, meaningful while rc_en=1
//   ivch     constant VC id served by this buffer
//   rc_en    route-compute enable, one pulse per packet
//   odata    front flit payload
//   otype    front flit type
//   ovalid   front flit may be forwarded
//   ogrant   downstream pops the front flit this cycle
//   ocredit  one-cycle credit return, the cycle after each pop
//   empty    FIFO holds no flits
//   err      sticky protocol error (overflow, orphan flit, stray head)
module inbuf_vc #(
    parameter int DATAW  = 32,
    parameter int ADDRW  = 8,
    parameter int VCHW   = 1,
    parameter int VCH_ID = 0,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW-1:0] idata,
    input  logic [1:0]       itype,
    input  logic             ivalid,
    output logic [ADDRW-1:0] addr,
    output logic [VCHW-1:0]  ivch,
    output logic             rc_en,
    output logic [DATAW-1:0] odata,
    output logic [1:0]       otype,
    output logic             ovalid,
    input  logic             ogrant,
    output logic             ocredit,
    output logic             empty,
    output logic             err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RC,
        ACTIVE
    } state_t;

    state_t           state, state_nxt;
    logic [DATAW+1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [DATAW+1:0] front;
    logic [1:0]       ftype;
    logic             pop, push, err_set;
    // Set while the packet's own head is still at the front in ACTIVE, so
    // only a later head flit is flagged as a protocol error.
    logic             first, first_nxt;

    assign front = mem[rd_ptr];
    assign ftype = front[DATAW+1:DATAW];
    assign empty = (count == '0);
    assign odata = front[DATAW-1:0];
    assign otype = ftype;
    assign addr  = front[ADDRW-1:0];
    assign ivch  = VCHW'(VCH_ID);

    always_comb begin
        state_nxt = state;
        first_nxt = first;
        rc_en     = 1'b0;
        ovalid    = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    if (ftype[0]) begin
                        rc_en     = 1'b1;
                        state_nxt = RC;
                    end else begin
                        // orphan body/tail: drop it, which still returns a credit
                        pop     = 1'b1;
                        err_set = 1'b1;
                    end
                end
            end
            RC: begin
                state_nxt = ACTIVE;
                first_nxt = 1'b1;
            end
            ACTIVE: begin
                ovalid = !empty;
                if (ovalid && !first && ftype[0])
                    err_set = 1'b1;
                if (ovalid && ogrant) begin
                    pop       = 1'b1;
                    first_nxt = 1'b0;
                    if (ftype[1])
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // a pop in the same cycle frees the slot, so a full FIFO can still accept
        push = ivalid && ((count != FULL) || pop);
        if (ivalid && (count == FULL) && !pop)
            err_set = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state   <= IDLE;
            first   <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ocredit <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            first   <= first_nxt;
            ocredit <= pop;
            if (err_set)
                err <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ && push)
            mem[wr_ptr] <= {itype, idata};
    end
endmodule
